// File: rtl/config_chain_sequencer.sv
// Purpose : serialises wr_data words LSB first into a configuration shift chain
//           on a divided ConfigClk, strobes ConfigLoad at the end, and (with
//           CFG_READBACK_EN defined) returns the bits shifted out of the chain
//           as rd_data words.
// Latency : each bit takes 2*CLK_DIV cycles; ConfigLoad stays high 2*CLK_DIV
//           cycles; done pulses one cycle after the load.
// Backpressure: ConfigClk parks low in FETCH until wr_valid (and, with
//           readback, until any pending rd_data is taken by rd_ready).
// Build option: `define CFG_READBACK_EN enables the readback path.
// Ports   : S_AXI_ACLK / S_AXI_ARESETN clock and async active-low reset;
//           start/abort/chain_len control; wr_* word input handshake;
//           rd_* readback output handshake; busy/done status;
//           ConfigClk/ConfigIn/ConfigLoad drive the chain, ConfigOut returns.
module config_chain_sequencer #(
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 13,
  parameter int CLK_DIV = 100
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESETN,
  input  logic              start,
  input  logic              abort,
  input  logic [LEN_W-1:0]  chain_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              busy,
  output logic              done,
  output logic              ConfigClk,
  output logic              ConfigIn,
  output logic              ConfigLoad,
  input  logic              ConfigOut
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam int DIV_W = $clog2(2 * CLK_DIV + 1);
  localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] FULL_LAST = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    SHIFT_LO = 3'd2,
    SHIFT_HI = 3'd3,
    LOAD     = 3'd4,
    FINISH   = 3'd5
  } state_t;

  state_t             state, state_nxt;
  logic [LEN_W-1:0]   len_rem;   // bits still to shift, including the current one
  logic [DATA_W-1:0]  word_q;    // current word, shifted right as bits go out
  logic [IDX_W-1:0]   bit_idx;   // position of the current bit within its word
  logic [DIV_W-1:0]   div_cnt;   // cycles spent in the current timed state

  logic clk_nxt, in_nxt, load_nxt;
  logic rd_block;                // a readback word is waiting for rd_ready
  logic kill, accept, half_end, load_end, last_bit, word_end, bit_end;

  assign kill     = abort && (state != IDLE);
  assign half_end = (div_cnt == HALF_LAST);
  assign load_end = (div_cnt == FULL_LAST);
  assign last_bit = (len_rem == LEN_W'(1));
  assign word_end = (bit_idx == IDX_LAST);
  assign bit_end  = (state == SHIFT_HI) && half_end && !abort;

  // len_rem==0 in FETCH means every bit is out and only the readback drain is left.
  assign wr_ready = (state == FETCH) && (len_rem != '0) && !rd_block && !abort;
  assign accept   = wr_valid && wr_ready;
  assign busy     = (state != IDLE);
  assign done     = (state == FINISH) && !abort;

  always_comb begin
    state_nxt = state;
    clk_nxt   = 1'b0;
    in_nxt    = ConfigIn;
    load_nxt  = 1'b0;
    case (state)
      IDLE: begin
        in_nxt = 1'b0;
        if (start && !abort) begin
          state_nxt = (chain_len == '0) ? FINISH : FETCH;
        end
      end
      FETCH: begin
        if (len_rem == '0) begin
          if (!rd_block) begin
            state_nxt = LOAD;
            load_nxt  = 1'b1;
            in_nxt    = 1'b0;
          end
        end else if (accept) begin
          state_nxt = SHIFT_LO;
          in_nxt    = wr_data[0];
        end
      end
      SHIFT_LO: begin
        if (half_end) begin
          state_nxt = SHIFT_HI;
          clk_nxt   = 1'b1;
        end
      end
      SHIFT_HI: begin
        clk_nxt = 1'b1;
        if (half_end) begin
          clk_nxt = 1'b0;
          if (last_bit) begin
            // The last readback word must be taken before the chain is loaded.
            if (rd_block) begin
              state_nxt = FETCH;
            end else begin
              state_nxt = LOAD;
              load_nxt  = 1'b1;
              in_nxt    = 1'b0;
            end
          end else if (word_end) begin
            state_nxt = FETCH;
          end else begin
            state_nxt = SHIFT_LO;
            in_nxt    = word_q[1];
          end
        end
      end
      LOAD: begin
        load_nxt = 1'b1;
        if (load_end) begin
          state_nxt = FINISH;
          load_nxt  = 1'b0;
        end
      end
      FINISH: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        in_nxt    = 1'b0;
      end
    endcase
    if (kill) begin
      state_nxt = IDLE;
      clk_nxt   = 1'b0;
      in_nxt    = 1'b0;
      load_nxt  = 1'b0;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state      <= IDLE;
      ConfigClk  <= 1'b0;
      ConfigIn   <= 1'b0;
      ConfigLoad <= 1'b0;
      div_cnt    <= '0;
      len_rem    <= '0;
      word_q     <= '0;
      bit_idx    <= '0;
    end else begin
      state      <= state_nxt;
      ConfigClk  <= clk_nxt;
      ConfigIn   <= in_nxt;
      ConfigLoad <= load_nxt;

      if (state_nxt != state) begin
        div_cnt <= '0;
      end else if (state == SHIFT_LO || state == SHIFT_HI || state == LOAD) begin
        div_cnt <= div_cnt + DIV_W'(1);
      end else begin
        div_cnt <= '0;
      end

      if (kill) begin
        len_rem <= '0;
        word_q  <= '0;
        bit_idx <= '0;
      end else begin
        if (state == IDLE && start && !abort) begin
          len_rem <= chain_len;
        end
        if (accept) begin
          word_q  <= wr_data;
          bit_idx <= '0;
        end
        if (bit_end) begin
          len_rem <= len_rem - LEN_W'(1);
          word_q  <= word_q >> 1;
          if (!word_end) begin
            bit_idx <= bit_idx + IDX_W'(1);
          end
        end
      end
    end
  end

`ifdef CFG_READBACK_EN
  logic [DATA_W-1:0] rd_acc;
  logic [DATA_W-1:0] rd_word;
  logic              capture;

  // ConfigOut is sampled on the same edge that raises ConfigClk.
  assign capture  = (state == SHIFT_LO) && (state_nxt == SHIFT_HI);
  assign rd_block = rd_valid;

  always_comb begin
    rd_word          = rd_acc;
    rd_word[bit_idx] = ConfigOut;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rd_acc   <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else if (kill) begin
      rd_acc   <= '0;
      rd_valid <= 1'b0;
    end else if (capture) begin
      // A full word or the final partial word (upper bits left zero) is published.
      if (word_end || last_bit) begin
        rd_data  <= rd_word;
        rd_valid <= 1'b1;
        rd_acc   <= '0;
      end else begin
        rd_acc <= rd_word;
      end
    end else if (rd_valid && rd_ready) begin
      rd_valid <= 1'b0;
    end
  end
`else
  logic unused_readback_inputs;

  assign rd_data  = '0;
  assign rd_valid = 1'b0;
  assign rd_block = 1'b0;
  assign unused_readback_inputs = rd_ready ^ ConfigOut;
`endif

endmodule

// File: tb/tb_config_chain_sequencer.sv
module tb_config_chain_sequencer;
  localparam int DATA_W  = 32;
  localparam int LEN_W   = 13;
  localparam int CLK_DIV = 2;

  logic              S_AXI_ACLK    = 1'b0;
  logic              S_AXI_ARESETN = 1'b0;
  logic              start         = 1'b0;
  logic              abort         = 1'b0;
  logic [LEN_W-1:0]  chain_len     = '0;
  logic [DATA_W-1:0] wr_data       = '0;
  logic              wr_valid      = 1'b0;
  logic              rd_ready      = 1'b1;
  logic              loop_en       = 1'b0;
  logic              wr_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              busy;
  logic              done;
  logic              ConfigClk;
  logic              ConfigIn;
  logic              ConfigLoad;
  logic              cfg_out;

  assign cfg_out = loop_en & ConfigIn;

  config_chain_sequencer #(
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W),
    .CLK_DIV(CLK_DIV)
  ) dut (
    .S_AXI_ACLK   (S_AXI_ACLK),
    .S_AXI_ARESETN(S_AXI_ARESETN),
    .start        (start),
    .abort        (abort),
    .chain_len    (chain_len),
    .wr_data      (wr_data),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .busy         (busy),
    .done         (done),
    .ConfigClk    (ConfigClk),
    .ConfigIn     (ConfigIn),
    .ConfigLoad   (ConfigLoad),
    .ConfigOut    (cfg_out)
  );

  always #5 S_AXI_ACLK = ~S_AXI_ACLK;

  int total = 0;
  int bad   = 0;

  // Event monitor, sampled on the falling edge away from the DUT's active edge.
  int                ncyc  = 0;
  int                rises = 0;
  int                loads = 0;
  int                dones = 0;
  int                rdn   = 0;
  logic              clk_prev = 1'b0;
  logic              hist     [0:1023];
  int                rise_cyc [0:1023];
  logic [DATA_W-1:0] rd_log   [0:63];

  always @(negedge S_AXI_ACLK) begin
    ncyc <= ncyc + 1;
    if (ConfigClk && !clk_prev) begin
      hist[rises]     <= ConfigIn;
      rise_cyc[rises] <= ncyc;
      rises           <= rises + 1;
    end
    clk_prev <= ConfigClk;
    if (ConfigLoad) loads <= loads + 1;
    if (done)       dones <= dones + 1;
    if (rd_valid && rd_ready) begin
      rd_log[rdn] <= rd_data;
      rdn         <= rdn + 1;
    end
  end

  task automatic cyc();
    @(posedge S_AXI_ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_seq(input int len);
    chain_len = LEN_W'(len);
    start     = 1'b1;
    cyc();
    start     = 1'b0;
  endtask

  task automatic push(input logic [DATA_W-1:0] d);
    int n = 0;
    wr_data  = d;
    wr_valid = 1'b1;
    while (wr_ready !== 1'b1 && n < 400) begin
      cyc();
      n++;
    end
    chk("push_ready", wr_ready, 1);
    cyc();
    wr_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 600) begin
      cyc();
      n++;
    end
    chk("done_seen", done, 1);
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_clk"},      ConfigClk,  0);
    chk({pfx, "_in"},       ConfigIn,   0);
    chk({pfx, "_load"},     ConfigLoad, 0);
    chk({pfx, "_wr_ready"}, wr_ready,   0);
    chk({pfx, "_rd_valid"}, rd_valid,   0);
    chk({pfx, "_rd_data"},  rd_data,    0);
    chk({pfx, "_busy"},     busy,       0);
    chk({pfx, "_done"},     done,       0);
  endtask

  initial begin
    int r0, r1, l0, d0, n, viol;
    logic [7:0]  v8;
    logic [31:0] v32;

    // Reset values, then quiet chain after release.
    repeat (3) cyc();
    chk_reset_vals("rst");
    S_AXI_ARESETN = 1'b1;
    repeat (10) cyc();
    chk("post_rst_rises", rises, 0);

    // 8 bits of 0xA5; a start pulse mid-shift must be ignored.
    r0 = rises; l0 = loads; d0 = dones;
    start_seq(8);
    chk("t1_busy", busy, 1);
    push(32'h0000_00A5);
    repeat (6) cyc();
    chain_len = 13'd3;
    start     = 1'b1;
    cyc();
    start     = 1'b0;
    wait_done();
    chk("t1_rises", rises - r0, 8);
    for (int i = 0; i < 8; i++) v8[i] = hist[r0 + i];
    chk("t1_bits", v8, 8'hA5);
    chk("t1_period", rise_cyc[r0 + 7] - rise_cyc[r0], 7 * 2 * CLK_DIV);
    chk("t1_load_cycles", loads - l0, 2 * CLK_DIV);
    cyc();
    chk("t1_done_off", done, 0);
    chk("t1_idle", busy, 0);
    repeat (5) cyc();
    chk("t1_done_count", dones - d0, 1);

    // 40 bits, second word 20 cycles late: clock parks low through the gap.
    r0 = rises; l0 = loads;
    start_seq(40);
    push(32'h1234_5678);
    n = 0;
    while (wr_ready !== 1'b1 && n < 400) begin cyc(); n++; end
    chk("t2_refetch", wr_ready, 1);
    r1 = rises; viol = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (ConfigClk !== 1'b0) viol++;
    end
    chk("t2_gap_clk_low", viol, 0);
    chk("t2_gap_no_rise", rises - r1, 0);
    push(32'h0000_00AB);
    wait_done();
    chk("t2_rises", rises - r0, 40);
    for (int i = 0; i < 32; i++) v32[i] = hist[r0 + i];
    chk("t2_word0", v32, 32'h1234_5678);
    for (int i = 0; i < 8; i++) v8[i] = hist[r0 + 32 + i];
    chk("t2_word1", v8, 8'hAB);
    chk("t2_load_cycles", loads - l0, 2 * CLK_DIV);
    repeat (3) cyc();

    // Abort during bit 5.
    r0 = rises; l0 = loads; d0 = dones;
    start_seq(16);
    push(32'h0000_FFFF);
    n = 0;
    while (rises - r0 < 5 && n < 200) begin cyc(); n++; end
    chk("ab_reached_bit5", rises - r0, 5);
    cyc();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("ab_idle", busy, 0);
    chk("ab_clk", ConfigClk, 0);
    chk("ab_in", ConfigIn, 0);
    chk("ab_load", ConfigLoad, 0);
    chk("ab_rd_valid", rd_valid, 0);
    r1 = rises;
    repeat (30) cyc();
    chk("ab_no_more_rises", rises - r1, 0);
    chk("ab_no_load", loads - l0, 0);
    chk("ab_no_done", dones - d0, 0);

    // Abort while a word is offered in FETCH: word is not taken.
    start_seq(8);
    wr_data  = 32'h0000_005A;
    wr_valid = 1'b1;
    abort    = 1'b1;
    #1;
    chk("abf_wr_ready", wr_ready, 0);
    cyc();
    abort    = 1'b0;
    wr_valid = 1'b0;
    chk("abf_idle", busy, 0);

    // start and abort together in IDLE: abort wins.
    chain_len = 13'd8;
    start = 1'b1;
    abort = 1'b1;
    cyc();
    start = 1'b0;
    abort = 1'b0;
    chk("sa_abort_wins", busy, 0);

    // Zero-length chain: done with no clock edge and no load.
    r0 = rises; l0 = loads; d0 = dones;
    start_seq(0);
    chk("z_busy", busy, 1);
    chk("z_done", done, 1);
    cyc();
    chk("z_done_off", done, 0);
    chk("z_idle", busy, 0);
    repeat (10) cyc();
    chk("z_no_rise", rises - r0, 0);
    chk("z_no_load", loads - l0, 0);
    chk("z_done_count", dones - d0, 1);

`ifdef CFG_READBACK_EN
    // Loopback: words come back unchanged, partial word zero-extended.
    loop_en  = 1'b1;
    rd_ready = 1'b1;
    n = rdn;
    start_seq(36);
    push(32'hDEAD_BEEF);
    push(32'h0000_0005);
    wait_done();
    repeat (3) cyc();
    chk("rb_word_count", rdn - n, 2);
    chk("rb_word0", rd_log[n], 32'hDEAD_BEEF);
    chk("rb_word1", rd_log[n + 1], 32'h0000_0005);

    // Readback stall: consumer withholds rd_ready after the first word.
    r0 = rises;
    rd_ready = 1'b0;
    n = rdn;
    start_seq(64);
    push(32'hA5A5_A5A5);
    d0 = 0;
    while (rd_valid !== 1'b1 && d0 < 400) begin cyc(); d0++; end
    chk("rs_valid_seen", rd_valid, 1);
    chk("rs_data", rd_data, 32'hA5A5_A5A5);
    wr_data  = 32'h3C3C_3C3C;
    wr_valid = 1'b1;
    repeat (3) cyc();
    r1 = rises; viol = 0;
    for (int i = 0; i < 47; i++) begin
      cyc();
      if (wr_ready !== 1'b0) viol++;
      if (ConfigClk !== 1'b0) viol++;
      if (rd_valid !== 1'b1) viol++;
    end
    chk("rs_stall", viol, 0);
    chk("rs_stall_no_rise", rises - r1, 0);
    rd_ready = 1'b1;
    push(32'h3C3C_3C3C);
    wait_done();
    repeat (3) cyc();
    chk("rs_rises", rises - r0, 64);
    chk("rs_word_count", rdn - n, 2);
    chk("rs_word0", rd_log[n], 32'hA5A5_A5A5);
    chk("rs_word1", rd_log[n + 1], 32'h3C3C_3C3C);
    loop_en = 1'b0;
`endif

    // Reset asserted mid-shift, while ConfigClk and ConfigIn are high.
    start_seq(8);
    push(32'h0000_00FF);
    r0 = rises;
    n = 0;
    while (!(rises - r0 >= 3 && ConfigClk === 1'b1) && n < 200) begin cyc(); n++; end
    chk("mr_clk_high", ConfigClk, 1);
    S_AXI_ARESETN = 1'b0;
    #1;
    chk_reset_vals("mr");
    repeat (3) cyc();
    S_AXI_ARESETN = 1'b1;
    r1 = rises;
    repeat (30) cyc();
    chk("mr_quiet_after", rises - r1, 0);
    chk("mr_idle_after", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/config_chain_sequencer.md
CONFIG_CHAIN_SEQUENCER -- requirements
Module: config_chain_sequencer

Interface
REQ-001 Parameters SHALL be: DATA_W, default 32, word width; LEN_W, default 13, chain-length counter width; CLK_DIV, default 100, ConfigClk half-period in ACLK cycles (at least 2).
REQ-002 The reset SHALL be S_AXI_ARESETN, asynchronous, active-low, and the clock SHALL be S_AXI_ACLK.
REQ-003 Ports SHALL be:
- S_AXI_ACLK  in  1  system clock
- S_AXI_ARESETN  in  1  async active-low reset
- start  in  1  pulse; begin a sequence
- abort  in  1  pulse; cancel the sequence
- chain_len  in  LEN_W  number of bits to shift; sampled at start
- wr_data  in  DATA_W  shift-in word
- wr_valid  in  1  wr_data valid
- wr_ready  out  1  word accepted
- rd_data  out  DATA_W  captured readback word
- rd_valid  out  1  rd_data valid
- rd_ready  in  1  consumer accepts rd_data
- busy  out  1  sequence active
- done  out  1  one-cycle completion pulse
- ConfigClk  out  1  divided shift clock
- ConfigIn  out  1  serial data to the chain
- ConfigLoad  out  1  parallel-load strobe
- ConfigOut  in  1  serial data from the chain

Function
REQ-004 The FSM SHALL have the states IDLE, FETCH, SHIFT_LO, SHIFT_HI, LOAD and FINISH.
REQ-005 In IDLE, start SHALL latch chain_len and go to FETCH; if chain_len==0, the FSM SHALL go to FINISH instead with no ConfigClk edge and no ConfigLoad.
REQ-006 start SHALL be ignored while busy=1; busy SHALL be 1 in every state except IDLE.
REQ-007 wr_ready SHALL be 1 only in FETCH; on the wr_valid&wr_ready cycle the word SHALL be latched and the next state SHALL be SHIFT_LO.
REQ-008 Bits SHALL be shifted LSB first; a partial final word's bits above the remaining length SHALL be ignored.
REQ-009 SHIFT_LO SHALL hold ConfigClk=0 for CLK_DIV cycles, with ConfigIn = current bit from its first cycle.
REQ-010 SHIFT_HI SHALL hold ConfigClk=1 for CLK_DIV cycles; ConfigOut SHALL be registered on the cycle ConfigClk rises.
REQ-011 Each bit SHALL take exactly 2*CLK_DIV ACLK cycles.
REQ-012 After SHIFT_HI:
- if bits remain in the word, the FSM SHALL go to SHIFT_LO;
- if the word is exhausted and bits remain, it SHALL go to FETCH;
- if the last bit is done, it SHALL go to LOAD.
REQ-013 In FETCH, ConfigClk SHALL stay 0 indefinitely while wr_valid=0 (stall, not error), with no glitches.
REQ-014 LOAD SHALL drive ConfigLoad=1 and ConfigClk=0 for 2*CLK_DIV cycles, then go to FINISH.
REQ-015 FINISH SHALL assert done for exactly one cycle, then return to IDLE.
REQ-016 abort in any non-IDLE state SHALL force IDLE on the next cycle with ConfigClk=0, ConfigLoad=0, ConfigIn=0 and rd_valid=0; no done SHALL be issued, and any un-accepted word SHALL be left unconsumed.
REQ-017 If abort and start are asserted in the same cycle, abort SHALL win.
REQ-018 The bit counter SHALL be LEN_W wide; chain_len up to 2^LEN_W-1 SHALL be supported without wrap-around.

Reset
REQ-019 Assertion SHALL immediately force the FSM to IDLE, including mid-shift.
REQ-020 Reset values SHALL be: ConfigClk=0, ConfigIn=0, ConfigLoad=0, wr_ready=0, rd_valid=0, rd_data=0, busy=0, done=0; all counters SHALL be reset to 0.
REQ-021 Deassertion SHALL be followed by no ConfigClk edge until a start.

Configuration
REQ-022 When CFG_READBACK_EN is defined:
- captured bits SHALL fill rd_data LSB first;
- rd_valid SHALL assert when a word of DATA_W bits, or the final partial word (upper bits zero), completes;
- rd_valid SHALL hold until rd_valid&rd_ready;
- FETCH SHALL NOT accept the next word while rd_valid=1 (ConfigClk stalls low);
- LOAD SHALL NOT be entered until the final readback word is accepted.
REQ-023 When CFG_READBACK_EN is undefined: rd_valid and rd_data SHALL be tied 0, rd_ready SHALL be ignored, and there SHALL be no readback stall.

Verification (CLK_DIV=2)
REQ-024 chain_len=8, word 0x000000A5 -> ConfigIn 1,0,1,0,0,1,0,1; 8 ConfigClk rises; ConfigLoad high 4 cycles; a single done pulse.
REQ-025 chain_len=40, second word offered 20 cycles late -> ConfigClk held low through the gap; exactly 40 rises.
REQ-026 READBACK_EN, ConfigOut looped to ConfigIn, chain_len=36, words 0xDEADBEEF, 0x00000005 -> rd words 0xDEADBEEF, then 0x00000005.
REQ-027 READBACK_EN, chain_len=64, rd_ready=0 for 50 cycles after the first rd_valid -> wr_ready stays 0 and ConfigClk stays low until the rd handshake.
REQ-028 abort during bit 5 -> IDLE next cycle; ConfigClk=0; no ConfigLoad; no done.
REQ-029 Two cases:
- start with chain_len=0 -> done pulse and no ConfigClk edge;
- reset asserted mid-shift -> all outputs at reset values immediately.
